// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Burst mode is selected by the FIFO_ARB_BURST_EN macro in fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int WR_COUNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
      w_pos = (w_pos == LAST_IDX) ? '0 : w_pos + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a grant hold the port for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_id,
  output logic [WR_COUNT_W-1:0]         wr_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + IDX_W'(1);
  endfunction

  arb_state_t              r_state, w_nextState;
  logic [IDX_W-1:0]        r_grantId, w_nextGrantId;
  logic [IDX_W-1:0]        r_lastId, w_nextLastId;
  logic [IDX_W-1:0]        w_start, w_pickIdx;
  logic                    w_pickFound, w_granted, w_accept, w_release, w_limitHit;
  logic [WR_COUNT_W-1:0]   r_wrCount;

`ifdef FIFO_ARB_BURST_EN
  logic [7:0] r_beatCnt, w_nextBeatCnt;
  assign w_limitHit = (9'(r_beatCnt) + 9'd1) == 9'(MAX_BURST);
`else
  assign w_limitHit = 1'b1;
`endif

  // While granted, the search starts just past the current owner so it ranks last.
  assign w_start = (r_state == ARB_GRANT) ? wrapInc(r_grantId) : wrapInc(r_lastId);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .start (w_start),
    .found (w_pickFound),
    .idx   (w_pickIdx)
  );

  assign w_granted   = (r_state == ARB_GRANT);
  assign w_accept    = w_granted && req_valid[r_grantId] && !fifo_full;
  assign w_release   = w_granted && (!req_valid[r_grantId] || (w_accept && w_limitHit));
  assign fifo_wr_en  = w_accept;
  assign grant_valid = w_granted;
  assign grant_id    = r_grantId;
  assign wr_count    = r_wrCount;

  always_comb begin
    req_ready = '0;
    fifo_data = '0;
    if (w_granted) begin
      req_ready[r_grantId] = !fifo_full;
      fifo_data = req_data[int'(r_grantId)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextGrantId = r_grantId;
    w_nextLastId  = r_lastId;
`ifdef FIFO_ARB_BURST_EN
    w_nextBeatCnt = w_accept ? r_beatCnt + 8'd1 : r_beatCnt;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_pickFound) begin
          w_nextState   = ARB_GRANT;
          w_nextGrantId = w_pickIdx;
`ifdef FIFO_ARB_BURST_EN
          w_nextBeatCnt = 8'd0;
`endif
        end
      end
      ARB_GRANT: begin
        if (w_release) begin
          w_nextLastId = r_grantId;
          if (w_pickFound) begin
            w_nextGrantId = w_pickIdx;
`ifdef FIFO_ARB_BURST_EN
            w_nextBeatCnt = 8'd0;
`endif
          end else begin
            w_nextState = ARB_IDLE;
          end
        end
      end
      default: w_nextState = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_grantId <= '0;
      r_lastId  <= LAST_IDX;
      r_wrCount <= '0;
`ifdef FIFO_ARB_BURST_EN
      r_beatCnt <= 8'd0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_grantId <= w_nextGrantId;
      r_lastId  <= w_nextLastId;
`ifdef FIFO_ARB_BURST_EN
      r_beatCnt <= w_nextBeatCnt;
`endif
      if (w_accept && (r_wrCount != '1)) begin
        r_wrCount <= r_wrCount + WR_COUNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO. It grants one requester at a time, muxes that requester's data onto the FIFO write port, and honours FIFO `full` backpressure. Fairness is round-robin. An optional burst mode lets a granted requester keep the port for several consecutive beats.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16
- `DATA_WIDTH`, 8: FIFO word width
- `MAX_BURST`, 4: maximum beats per grant when burst mode is compiled in, 1..255
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  one-hot or zero; beat i accepted when `req_valid[i] && req_ready[i]`
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr_en`  out  1  FIFO write enable
- `fifo_data`  out  DATA_WIDTH  FIFO write data
- `grant_valid`  out  1  a grant is held
- `grant_id`  out  $clog2(NUM_REQ)  index of the granted requester
- `wr_count`  out  16  beats written since reset, saturating at 16'hFFFF

## Operation
- FSM states: IDLE and GRANT.
- Behaviour in IDLE:
  - `grant_valid`=0 and `req_ready`=0.
  - If any `req_valid` is high, the next grant goes to the first valid index found by searching from `last_id+1` with wrap. The FSM moves to GRANT and `beat_cnt` is set to 0.
- Behaviour in GRANT with g = `grant_id`:
  - `req_ready[g]` = `!fifo_full`.
  - `fifo_wr_en` = `req_valid[g] && !fifo_full`.
  - `fifo_data` = slice g of `req_data`. It is driven whenever a grant is held and is 0 otherwise.
- An accepted beat increments `beat_cnt` and `wr_count`.
- Release condition, evaluated every GRANT cycle:
  - `req_valid[g]`=0, or
  - the accepted beat brings `beat_cnt+1` to the beat limit. The limit is 1 without burst mode and `MAX_BURST` with it.
- On release:
  - `last_id` is set to g.
  - If any `req_valid` is high, re-arbitrate in the same cycle, searching from g+1 with wrap. g itself is the lowest priority. The FSM stays in GRANT.
  - If no `req_valid` is high, go to IDLE.
- `fifo_full` while granted: the beat is not accepted and not counted, and the grant is held. There is no timeout.
- A requester must not drop `req_valid` while `req_ready` is low mid-beat. Data is assumed stable while valid. Violations are not detected.
- Reset values:
  - `last_id` = `NUM_REQ-1`, so requester 0 has first priority.
  - All outputs are 0 and the state is IDLE.

## Timing
- `req_ready`, `fifo_wr_en` and `fifo_data` are combinational from the registered grant plus `fifo_full`/`req_valid`. There are no combinational paths from `req_valid` of non-granted ports.
- `grant_valid`, `grant_id`, `beat_cnt`, `last_id` and `wr_count` are registered.
- The first grant from IDLE costs 1 bubble cycle: request at cycle n, first write at n+1.
- Back-to-back handover between requesters has zero bubble cycles.
- Reset assertion is asynchronous. A beat in flight at the reset edge is not counted.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - The beat limit per grant is `MAX_BURST`.
  - `beat_cnt` is an 8-bit register.
- `FIFO_ARB_BURST_EN` undefined:
  - The beat limit is 1, which gives strict per-beat round-robin.
  - `beat_cnt` logic is removed and `MAX_BURST` is ignored.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` (ARB_IDLE, ARB_GRANT)
  - the `WR_COUNT_W`=16 constant
  - a `clog2`-based index width helper
- Sub-module `rr_pick`:
  - combinational round-robin search
  - inputs: `req` vector and `start` index
  - outputs: `found` and `idx`
  - instantiated once in the top module.

## Test plan
- Reset: hold `reset`=0 with all `req_valid`=1, then release → `grant_id`=0 one cycle later; first write carries requester 0 data.
- Fairness, burst off: all 4 requesters continuously valid with data 8'h10..8'h13 → FIFO sees 10,11,12,13,10,… on consecutive cycles with no gaps.
- Backpressure: requester 2 granted, `fifo_full`=1 for 5 cycles → `fifo_wr_en`=0, `grant_id` stays 2, `wr_count` unchanged; write resumes the cycle `full` falls.
- Burst on (`MAX_BURST`=4): requesters 0 and 1 continuously valid → pattern 0,0,0,0,1,1,1,1,0,…
- Burst on, early release: requester 3 drops valid after 2 beats while requester 1 is valid → next cycle `grant_id`=1; `wr_count` increases by exactly 2 for requester 3.
- Async reset mid-burst: assert `reset` low between clock edges → outputs 0 immediately, `wr_count`=0, first grant after release goes to requester 0.
